// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, addresses the synchronous instruction BRAM
// and registers the returned word into the decode fields with stall/redirect handling.
//
// state | meaning
// IDLE  | pc parked at 0, nothing in flight, waiting for start
// RUN   | fetching one word per cycle; left only by reset
module instruction_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [3:0]         id_opcode,
  output logic [3:0]         id_rd,
  output logic [3:0]         id_ra,
  output logic [3:0]         id_rb,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic [15:0]        fetch_count
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic              state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_valid;
  logic              hold;

  // During a stall the BRAM is re-addressed with the in-flight word so im_data stays valid.
  assign hold    = (state == RUN) && stall && !br_taken;
  assign im_addr = hold ? fetch_pc : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
      id_opcode   <= 4'd0;
      id_rd       <= 4'd0;
      id_ra       <= 4'd0;
      id_rb       <= 4'd0;
      id_pc       <= '0;
      id_valid    <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          pc          <= '0;
          fetch_pc    <= '0;
          fetch_valid <= 1'b0;
          id_opcode   <= 4'd0;
          id_rd       <= 4'd0;
          id_ra       <= 4'd0;
          id_rb       <= 4'd0;
          id_pc       <= '0;
          id_valid    <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (br_taken) begin
            pc          <= br_target;
            fetch_valid <= 1'b0;
            id_opcode   <= 4'd0;
            id_rd       <= 4'd0;
            id_ra       <= 4'd0;
            id_rb       <= 4'd0;
            id_pc       <= '0;
            id_valid    <= 1'b0;
          end else if (!stall) begin
            pc          <= pc + ADDR_W'(1);
            fetch_pc    <= pc;
            fetch_valid <= 1'b1;
            if (fetch_valid) begin
              id_opcode <= im_data[15:12];
              id_rd     <= im_data[11:8];
              id_ra     <= im_data[7:4];
              id_rb     <= im_data[3:0];
              id_pc     <= fetch_pc;
              id_valid  <= 1'b1;
              if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            end else begin
              id_opcode <= 4'd0;
              id_rd     <= 4'd0;
              id_ra     <= 4'd0;
              id_rb     <= 4'd0;
              id_pc     <= '0;
              id_valid  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
